// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator: moves at most STEP bit positions per clock until
// the requested amount is consumed, then holds the result under valid/ready.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    shamt,
  // operation select; "type" is a reserved word so the port is named op
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             busy
);

  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  localparam logic [2:0] OP_SRL = 3'd0;
  localparam logic [2:0] OP_SLL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [SW-1:0]    rem, rem_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [SW-1:0]    k;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic             accept;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign r         = work;

  // Per-cycle step size; the final partial step consumes whatever remains.
  assign k     = (rem < STEP_W) ? rem : STEP_W;
  assign rot_r = {work, work} >> k;
  assign rot_l = {work, work} << k;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      op_q  <= OP_SRL;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      rem   <= rem_nxt;
      op_q  <= op_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    rem_nxt   = rem;
    op_nxt    = op_q;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          op_nxt = op;
          // Reserved ops and zero shifts finish without entering BUSY.
          if (op > OP_ROL) begin
            work_nxt  = '0;
            rem_nxt   = '0;
            state_nxt = DONE;
          end else if (shamt == '0) begin
            work_nxt  = a;
            rem_nxt   = '0;
            state_nxt = DONE;
          end else begin
            work_nxt  = a;
            rem_nxt   = shamt;
            state_nxt = BUSY;
          end
        end else if (state == DONE && out_ready) begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        case (op_q)
          OP_SRL:  work_nxt = work >> k;
          OP_SLL:  work_nxt = work << k;
          OP_SRA:  work_nxt = $unsigned($signed(work) >>> k);
          OP_ROR:  work_nxt = rot_r[WIDTH-1:0];
          OP_ROL:  work_nxt = rot_l[2*WIDTH-1:WIDTH];
          default: work_nxt = '0;
        endcase
        rem_nxt = rem - k;
        if (rem_nxt == '0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: four WIDTH=32 instances with STEP 1,2,4,8
// share clock and reset; expected result/latency is queued at drive time.
module tb_iter_shifter;

  logic        clk;
  logic        rst;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [31:0] a         [4];
  logic [4:0]  shamt     [4];
  logic [2:0]  op        [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] r         [4];
  logic        busy      [4];

  typedef struct {
    logic [31:0] r;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    iter_shifter #(.WIDTH(32), .STEP(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .shamt     (shamt[g]),
      .op        (op[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .r         (r[g]),
      .busy      (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] modelR(logic [31:0] av, logic [4:0] sv, logic [2:0] tv);
    logic [63:0] dbl;
    dbl = {av, av};
    case (tv)
      3'd0: return av >> sv;
      3'd1: return av << sv;
      3'd2: return $unsigned($signed(av) >>> sv);
      3'd3: begin dbl = dbl >> sv; return dbl[31:0]; end
      3'd4: begin dbl = dbl << sv; return dbl[63:32]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int modelLat(logic [4:0] sv, logic [2:0] tv, int step);
    if (tv > 3'd4 || sv == 5'd0) return 1;
    return 1 + (int'(sv) + step - 1) / step;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request, queue its expectation, and return just after the accept edge.
  task automatic applyStimulus(input int idx, input logic [31:0] av, input logic [4:0] sv,
                               input logic [2:0] tv);
    int   wait_cnt;
    exp_t e;
    wait_cnt      = 0;
    a[idx]        = av;
    shamt[idx]    = sv;
    op[idx]       = tv;
    in_valid[idx] = 1'b1;
    e.r   = modelR(av, sv, tv);
    e.lat = modelLat(sv, tv, 1 << idx);
    sbq.push_back(e);
    while (!in_ready[idx] && wait_cnt < 200) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    if (wait_cnt >= 200) checkOutput("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
  endtask

  task automatic collectResult(input int idx, input string tag);
    int   cycles;
    int   busy_cnt;
    exp_t e;
    cycles   = 1;
    busy_cnt = busy[idx] ? 1 : 0;
    while (!out_valid[idx] && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      if (busy[idx]) busy_cnt++;
    end
    checkOutput({tag, "_valid"}, 64'(out_valid[idx]), 64'd1);
    if (sbq.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sbq.pop_front();
      checkOutput({tag, "_r"}, 64'(r[idx]), 64'(e.r));
      checkOutput({tag, "_lat"}, 64'(cycles), 64'(e.lat));
      checkOutput({tag, "_busy"}, 64'(busy_cnt), 64'(e.lat - 1));
    end
  endtask

  initial begin
    logic [31:0] hold_r;
    int          ov_cnt;
    int          idx;
    logic [31:0] av;
    logic [4:0]  sv;
    logic [2:0]  tv;

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      a[i]         = 32'h0;
      shamt[i]     = 5'd0;
      op[i]        = 3'd0;
      out_ready[i] = 1'b1;
    end

    // Reset state, checked while reset is held.
    #2;
    for (int i = 0; i < 4; i++) begin
      checkOutput("rst_out_valid", 64'(out_valid[i]), 64'd0);
      checkOutput("rst_busy", 64'(busy[i]), 64'd0);
      checkOutput("rst_r", 64'(r[i]), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready[i]), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;

    // First accept lands on the first rising edge after release.
    applyStimulus(0, 32'h8000_0001, 5'd4, 3'd0);
    collectResult(0, "srl_s1");
    checkOutput("srl_s1_const", 64'(r[0]), 64'h0800_0000);

    applyStimulus(2, 32'h8000_0000, 5'd31, 3'd2);
    collectResult(2, "sra_s4");
    checkOutput("sra_s4_const", 64'(r[2]), 64'hFFFF_FFFF);

    applyStimulus(1, 32'h1234_5678, 5'd8, 3'd3);
    collectResult(1, "ror_s2");
    checkOutput("ror_s2_const", 64'(r[1]), 64'h7812_3456);
    applyStimulus(1, 32'h1234_5678, 5'd0, 3'd4);
    collectResult(1, "rol0_s2");

    // Backpressure, then back-to-back accept when the consumer frees up.
    out_ready[0] = 1'b0;
    applyStimulus(0, 32'hF0F0_1234, 5'd3, 3'd0);
    collectResult(0, "bp_first");
    hold_r = modelR(32'hF0F0_1234, 5'd3, 3'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold_valid", 64'(out_valid[0]), 64'd1);
      checkOutput("bp_hold_r", 64'(r[0]), 64'(hold_r));
      checkOutput("bp_hold_in_ready", 64'(in_ready[0]), 64'd0);
    end
    out_ready[0] = 1'b1;
    #1;
    applyStimulus(0, 32'h0000_00FF, 5'd6, 3'd1);
    collectResult(0, "bp_second");

    // Reserved operation codes.
    applyStimulus(1, 32'hCAFE_BABE, 5'd17, 3'd7);
    collectResult(1, "rsv7");
    applyStimulus(3, 32'hFFFF_FFFF, 5'd9, 3'd5);
    collectResult(3, "rsv5");

    // Reset during BUSY abandons the operation.
    applyStimulus(0, 32'hDEAD_BEEF, 5'd20, 3'd1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("abort_busy_before", 64'(busy[0]), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid[0]), 64'd0);
    checkOutput("abort_busy", 64'(busy[0]), 64'd0);
    checkOutput("abort_r", 64'(r[0]), 64'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) ov_cnt++;
    end
    checkOutput("abort_no_result", 64'(ov_cnt), 64'd0);

    // Random traffic across all STEP variants.
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 3));
      av  = $urandom;
      sv  = 5'($urandom_range(0, 31));
      tv  = 3'($urandom_range(0, 7));
      applyStimulus(idx, av, sv, tv);
      collectResult(idx, "rand");
    end

    checkOutput("sb_drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
